highlight_gauss_filter_pipe: RTL

- Parametrised successor to the RGB highlight suppressor, inserted in the ISP chain after colour processing and before display/DDR write.
- Accepts NUM_CH channels of DATA_WIDTH-bit pixel data on a vsync/hsync/href video stream.
- Owns its 3x3 window generation: two line buffers per channel.
- Applies a rounded 1-2-1 Gaussian blur selected by a runtime mode and a runtime threshold that is evaluated on the window centre. Output data and sync are exactly co-timed; per-frame highlight statistics are reported.

---
 rtl/isp_filter_pkg.sv | 29 ++
 rtl/linebuf_3x3_window.sv | 106 ++++++++++
 rtl/highlight_gauss_filter_pipe.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/isp_filter_pkg.sv
// Shared definitions for the ISP highlight / Gaussian filter pipeline.
//   mode_e      : runtime filter mode encoding (3 behaves as highlight-suppress)
//   G_W_*       : 1-2-1 separable Gaussian weights (corner / edge / centre)
//   G_SHIFT     : normalisation shift, G_ROUND the matching rounding offset
//   LAT         : fixed input-to-output latency in clocks
package isp_filter_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_HL     = 2'd1,
    MODE_BLUR   = 2'd2,
    MODE_HL_ALT = 2'd3
  } mode_e;

  localparam int unsigned LAT        = 3;
  localparam int unsigned G_W_CORNER = 1;
  localparam int unsigned G_W_EDGE   = 2;
  localparam int unsigned G_W_CENTRE = 4;
  localparam int unsigned G_SHIFT    = 4;
  localparam int unsigned G_ROUND    = 1 << (G_SHIFT - 1);

  // Weight of window tap (i = row, j = column), both 0..2 with 1 the centre.
  function automatic int unsigned g_weight(input int unsigned i, input int unsigned j);
    if (i == 1 && j == 1) return G_W_CENTRE;
    else if (i == 1 || j == 1) return G_W_EDGE;
    else return G_W_CORNER;
  endfunction

endpackage

// File: rtl/linebuf_3x3_window.sv
// 3x3 window generator: two line buffers, tap shift registers, col/row counters.
//   clk, rst_n    : clock, async active-low reset
//   vsync, href   : input frame sync and active-pixel qualifier
//   pix           : input pixel, NUM_CH channels packed
//   window        : registered 3x3 window, tap (i,j) at [(i*3+j)*PIX_W +: PIX_W],
//                   i=0 top row, j=0 left column; centre is the pixel at (row-1, col-1)
//   row, col      : registered slot coordinates of the pixel that produced window
//   valid         : registered href of that pixel
//   frame_start_c : combinational vsync rising edge
module linebuf_3x3_window #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned MAX_WIDTH  = 1280,
  parameter int unsigned ROW_BITS   = 11,
  parameter int unsigned COL_BITS   = $clog2(MAX_WIDTH + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             vsync,
  input  logic                             href,
  input  logic [NUM_CH*DATA_WIDTH-1:0]     pix,
  output logic [9*NUM_CH*DATA_WIDTH-1:0]   window,
  output logic [ROW_BITS-1:0]              row,
  output logic [COL_BITS-1:0]              col,
  output logic                             valid,
  output logic                             frame_start_c
);

  localparam int unsigned PIX_W  = NUM_CH * DATA_WIDTH;
  localparam int unsigned ADDR_W = $clog2(MAX_WIDTH);

  logic                 vsync_q;
  logic                 href_q;
  logic [ROW_BITS-1:0]  row_cnt;
  logic [COL_BITS-1:0]  col_cnt;
  logic                 in_range_c;
  logic [ADDR_W-1:0]    addr_c;
  logic [ROW_BITS-1:0]  slot_row_c;
  logic [PIX_W-1:0]     top_c;
  logic [PIX_W-1:0]     mid_c;
  logic [PIX_W-1:0]     lb1 [MAX_WIDTH];
  logic [PIX_W-1:0]     lb2 [MAX_WIDTH];
  logic [2:0][2:0][PIX_W-1:0] taps;

  assign frame_start_c = vsync & ~vsync_q;
  assign in_range_c    = col_cnt < COL_BITS'(MAX_WIDTH);
  // Out-of-range columns read a harmless address; their output is forced to 0.
  assign addr_c        = in_range_c ? ADDR_W'(col_cnt) : '0;
  // A pixel coinciding with the vsync rise already belongs to row 0.
  assign slot_row_c    = frame_start_c ? '0 : row_cnt;
  assign top_c         = lb2[addr_c];
  assign mid_c         = lb1[addr_c];
  assign window        = taps;

  // Column / row counters and edge-detect history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      row_cnt <= '0;
      col_cnt <= '0;
    end else begin
      vsync_q <= vsync;
      href_q  <= href;
      if (href) begin
        if (in_range_c) col_cnt <= col_cnt + COL_BITS'(1);
      end else begin
        col_cnt <= '0;
      end
      if (frame_start_c) row_cnt <= '0;
      else if (href_q && !href) row_cnt <= row_cnt + ROW_BITS'(1);
    end
  end

  // Line buffers: lb1 holds the previous line, lb2 the one before it.
  always_ff @(posedge clk) begin
    if (href && in_range_c) begin
      lb1[addr_c] <= pix;
      lb2[addr_c] <= mid_c;
    end
  end

  // Tap shift registers and slot tag; column 2 is the newest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps  <= '0;
      row   <= '0;
      col   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= href;
      row   <= slot_row_c;
      col   <= col_cnt;
      if (href) begin
        for (int unsigned i = 0; i < 3; i++) begin
          taps[i][0] <= taps[i][1];
          taps[i][1] <= taps[i][2];
        end
        taps[0][2] <= top_c;
        taps[1][2] <= mid_c;
        taps[2][2] <= pix;
      end
    end
  end

endmodule

// File: rtl/highlight_gauss_filter_pipe.sv
// Highlight-suppress / Gaussian blur filter on a vsync/hsync/href pixel stream.
//   clk, rst_n        : pixel clock, async active-low reset
//   cfg_mode          : 0 bypass, 1/3 highlight-suppress, 2 blur-all (latched at vsync rise)
//   cfg_threshold     : strict greater-than highlight threshold (latched at vsync rise)
//   per_frame_*       : input syncs and pixel
//   post_frame_*      : syncs delayed by LAT clocks
//   post_img_data     : filtered pixel, 0 whenever post_frame_href is low
//   stat_hl_count     : highlight centres of the previous frame, saturating
//   stat_overflow     : a line of the current frame exceeded MAX_WIDTH
module highlight_gauss_filter_pipe
  import isp_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_CH     = 3,
  parameter int unsigned MAX_WIDTH  = 1280,
  parameter int unsigned ROW_BITS   = 11,
  parameter int unsigned CNT_BITS   = 21
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [1:0]                    cfg_mode,
  input  logic [DATA_WIDTH-1:0]         cfg_threshold,
  input  logic                          per_frame_vsync,
  input  logic                          per_frame_hsync,
  input  logic                          per_frame_href,
  input  logic [NUM_CH*DATA_WIDTH-1:0]  per_img_data,
  output logic                          post_frame_vsync,
  output logic                          post_frame_hsync,
  output logic                          post_frame_href,
  output logic [NUM_CH*DATA_WIDTH-1:0]  post_img_data,
  output logic [CNT_BITS-1:0]           stat_hl_count,
  output logic                          stat_overflow
);

  localparam int unsigned PIX_W    = NUM_CH * DATA_WIDTH;
  localparam int unsigned COL_BITS = $clog2(MAX_WIDTH + 1);
  localparam int unsigned SUM_W    = DATA_WIDTH + 4;

  logic [9*PIX_W-1:0]   window;
  logic [ROW_BITS-1:0]  s1_row;
  logic [COL_BITS-1:0]  s1_col;
  logic                 s1_valid;
  logic                 frame_start_c;

  linebuf_3x3_window #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_CH     (NUM_CH),
    .MAX_WIDTH  (MAX_WIDTH),
    .ROW_BITS   (ROW_BITS),
    .COL_BITS   (COL_BITS)
  ) u_window (
    .clk           (clk),
    .rst_n         (rst_n),
    .vsync         (per_frame_vsync),
    .href          (per_frame_href),
    .pix           (per_img_data),
    .window        (window),
    .row           (s1_row),
    .col           (s1_col),
    .valid         (s1_valid),
    .frame_start_c (frame_start_c)
  );

  mode_e                 mode_q;
  logic [DATA_WIDTH-1:0] thr_q;
  mode_e                 mode_in_c;
  logic [DATA_WIDTH-1:0] thr_in_c;
  mode_e                 s1_mode;
  logic [DATA_WIDTH-1:0] s1_thr;
  logic [PIX_W-1:0]      s1_pix;

  assign mode_in_c = frame_start_c ? mode_e'(cfg_mode) : mode_q;
  assign thr_in_c  = frame_start_c ? cfg_threshold : thr_q;

  // Per-frame configuration latch plus stage-1 tag travelling with the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_BYPASS;
      thr_q   <= '0;
      s1_mode <= MODE_BYPASS;
      s1_thr  <= '0;
      s1_pix  <= '0;
    end else begin
      mode_q  <= mode_in_c;
      thr_q   <= thr_in_c;
      s1_mode <= mode_in_c;
      s1_thr  <= thr_in_c;
      s1_pix  <= per_img_data;
    end
  end

  logic [NUM_CH-1:0][SUM_W-1:0] sum_c;
  logic [PIX_W-1:0]             gauss_c;
  logic [PIX_W-1:0]             centre_c;
  logic                         hl_c;
  logic                         zero_c;
  logic                         border_c;
  logic                         count_c;

  assign centre_c = window[4*PIX_W +: PIX_W];
  assign zero_c   = (s1_row == '0) || (s1_col == '0) || (s1_col >= COL_BITS'(MAX_WIDTH));
  assign border_c = (s1_row == ROW_BITS'(1)) || (s1_col == COL_BITS'(1));
  assign count_c  = s1_valid && !zero_c && !border_c && (s1_mode != MODE_BYPASS) && hl_c;

  // Weighted 3x3 sum per channel; max 16*(2^DW-1)+8 fits DATA_WIDTH+4 bits.
  always_comb begin
    sum_c   = '0;
    gauss_c = '0;
    hl_c    = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      for (int unsigned i = 0; i < 3; i++) begin
        for (int unsigned j = 0; j < 3; j++) begin
          sum_c[k] = sum_c[k]
                   + SUM_W'(window[((i*3 + j)*NUM_CH + k)*DATA_WIDTH +: DATA_WIDTH])
                   * SUM_W'(g_weight(i, j));
        end
      end
      sum_c[k] = sum_c[k] + SUM_W'(G_ROUND);
      gauss_c[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(sum_c[k] >> G_SHIFT);
      if (centre_c[k*DATA_WIDTH +: DATA_WIDTH] > s1_thr) hl_c = 1'b1;
    end
  end

  mode_e            s2_mode;
  logic [PIX_W-1:0] s2_gauss;
  logic [PIX_W-1:0] s2_centre;
  logic [PIX_W-1:0] s2_pix;
  logic             s2_zero;
  logic             s2_border;
  logic             s2_hl;

  // Stage 2: arithmetic results and decision flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_mode   <= MODE_BYPASS;
      s2_gauss  <= '0;
      s2_centre <= '0;
      s2_pix    <= '0;
      s2_zero   <= 1'b0;
      s2_border <= 1'b0;
      s2_hl     <= 1'b0;
    end else begin
      s2_mode   <= s1_mode;
      s2_gauss  <= gauss_c;
      s2_centre <= centre_c;
      s2_pix    <= s1_pix;
      s2_zero   <= zero_c;
      s2_border <= border_c;
      s2_hl     <= hl_c;
    end
  end

  logic [PIX_W-1:0] out_c;

  // Output priority: bypass, masked border, pass-through border, blur/suppress.
  always_comb begin
    out_c = '0;
    if (s2_mode == MODE_BYPASS) out_c = s2_pix;
    else if (s2_zero) out_c = '0;
    else if (s2_border) out_c = s2_centre;
    else if (s2_mode == MODE_BLUR || s2_hl) out_c = s2_gauss;
    else out_c = s2_centre;
  end

  logic [2:0] sync_s1;
  logic [2:0] sync_s2;

  // Sync delay line {vsync, hsync, href}; data is gated by the same href.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_s1          <= '0;
      sync_s2          <= '0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_data    <= '0;
    end else begin
      sync_s1          <= {per_frame_vsync, per_frame_hsync, per_frame_href};
      sync_s2          <= sync_s1;
      post_frame_vsync <= sync_s2[2];
      post_frame_hsync <= sync_s2[1];
      post_frame_href  <= sync_s2[0];
      post_img_data    <= sync_s2[0] ? out_c : '0;
    end
  end

  logic [CNT_BITS-1:0] hl_cnt;

  // Frame statistics, handed over and restarted on each vsync rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hl_cnt        <= '0;
      stat_hl_count <= '0;
      stat_overflow <= 1'b0;
    end else begin
      if (frame_start_c) begin
        stat_hl_count <= hl_cnt;
        hl_cnt        <= '0;
      end else if (count_c && hl_cnt != '1) begin
        hl_cnt <= hl_cnt + CNT_BITS'(1);
      end
      if (frame_start_c) stat_overflow <= 1'b0;
      else if (s1_valid && s1_col == COL_BITS'(MAX_WIDTH)) stat_overflow <= 1'b1;
    end
  end

endmodule
